// File: rtl/elev_pkg.sv
// Shared types and helpers for the elevator call scheduler.
package elev_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2,
        DOOR    = 2'd3
    } elev_state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int floor_w(input int num_floors);
        return (num_floors < 2) ? 1 : $clog2(num_floors);
    endfunction

endpackage

// File: rtl/elev_call_reg.sv
// Pending up/down hall and car call storage with set/clear/absorb handling
// and above/below reductions relative to the current floor.
module elev_call_reg
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = floor_w(NUM_FLOORS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  hall_valid_i,
    input  logic [FLOOR_W-1:0]    hall_floor_i,
    input  logic                  hall_up_i,
    input  logic                  car_valid_i,
    input  logic [FLOOR_W-1:0]    car_floor_i,
    input  logic [FLOOR_W-1:0]    cur_floor_i,
    input  logic                  absorb_i,
    input  logic                  dir_up_i,
    input  logic [NUM_FLOORS-1:0] clr_up_i,
    input  logic [NUM_FLOORS-1:0] clr_dn_i,
    input  logic [NUM_FLOORS-1:0] clr_car_i,
    output logic [NUM_FLOORS-1:0] up_pending_o,
    output logic [NUM_FLOORS-1:0] dn_pending_o,
    output logic [NUM_FLOORS-1:0] car_pending_o,
    output logic [NUM_FLOORS-1:0] cf_oh_o,
    output logic                  above_o,
    output logic                  below_o
);

    localparam logic [NUM_FLOORS-1:0] ONE     = {{(NUM_FLOORS-1){1'b0}}, 1'b1};
    localparam logic [NUM_FLOORS-1:0] TOP_BIT = ONE << (NUM_FLOORS - 1);

    logic [NUM_FLOORS-1:0] up_q, dn_q, car_q;
    logic [NUM_FLOORS-1:0] hall_oh_s, car_oh_s, cf_oh_s, all_s, le_mask_s;
    logic [NUM_FLOORS-1:0] up_set_s, dn_set_s, car_set_s;

    // Shifting past the vector width yields zero, so out-of-range floors drop out here.
    assign hall_oh_s = hall_valid_i ? (ONE << hall_floor_i) : '0;
    assign car_oh_s  = car_valid_i  ? (ONE << car_floor_i)  : '0;
    assign cf_oh_s   = ONE << cur_floor_i;

    // Set vectors: impossible buttons masked, same-floor calls absorbed while the door is open.
    always_comb begin
        up_set_s  = '0;
        dn_set_s  = '0;
        car_set_s = car_oh_s;
        if (hall_up_i) begin
            up_set_s = hall_oh_s & ~TOP_BIT;
        end else begin
            dn_set_s = hall_oh_s & ~ONE;
        end
        if (absorb_i) begin
            car_set_s = car_set_s & ~cf_oh_s;
            if (dir_up_i) begin
                up_set_s = up_set_s & ~cf_oh_s;
            end else begin
                dn_set_s = dn_set_s & ~cf_oh_s;
            end
        end else begin
            car_set_s = car_oh_s;
        end
    end

    // Pending registers; a clear on the same bit beats a new set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            up_q  <= '0;
            dn_q  <= '0;
            car_q <= '0;
        end else begin
            up_q  <= (up_q  | up_set_s)  & ~clr_up_i;
            dn_q  <= (dn_q  | dn_set_s)  & ~clr_dn_i;
            car_q <= (car_q | car_set_s) & ~clr_car_i;
        end
    end

    assign all_s     = up_q | dn_q | car_q;
    assign le_mask_s = (cf_oh_s << 1'b1) - ONE;

    assign above_o       = |(all_s & ~le_mask_s);
    assign below_o       = |(all_s & (cf_oh_s - ONE));
    assign up_pending_o  = up_q;
    assign dn_pending_o  = dn_q;
    assign car_pending_o = car_q;
    assign cf_oh_o       = cf_oh_s;

endmodule

// File: rtl/elevator_call_scheduler.sv
// Collective (SCAN) elevator scheduler: call storage plus IDLE/MOVE/DOOR FSM.
// Optional idle return to HOME_FLOOR is enabled with ELEV_IDLE_RETURN_EN.
module elevator_call_scheduler
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS   = 4,
    parameter int FLOOR_W      = floor_w(NUM_FLOORS),
    parameter int HOME_FLOOR   = 0,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  hall_valid_i,
    input  logic [FLOOR_W-1:0]    hall_floor_i,
    input  logic                  hall_up_i,
    input  logic                  car_valid_i,
    input  logic [FLOOR_W-1:0]    car_floor_i,
    input  logic [FLOOR_W-1:0]    current_floor_i,
    input  logic                  arrived_i,
    input  logic                  door_done_i,
    output logic                  move_req_o,
    output logic                  dir_up_o,
    output logic                  open_door_o,
    output logic                  stop_ack_o,
    output logic [NUM_FLOORS-1:0] up_pending_o,
    output logic [NUM_FLOORS-1:0] dn_pending_o,
    output logic [NUM_FLOORS-1:0] car_pending_o
);

    localparam logic [FLOOR_W-1:0] TOP_F  = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0] HOME_F = FLOOR_W'(HOME_FLOOR);

    elev_state_e state_q, state_d;
    logic dir_q, dir_d, move_q, move_d, open_q, open_d, ack_q, ack_d;

    logic [NUM_FLOORS-1:0] up_s, dn_s, car_s, cf_oh_s;
    logic [NUM_FLOORS-1:0] clr_up_s, clr_dn_s, clr_car_s;
    logic above_reg_s, below_reg_s, above_s, below_s, ahead_s, behind_s;
    logic up_here_s, dn_here_s, car_here_s, call_here_s, fwd_here_s, rev_here_s;
    logic end_floor_s, any_call_s, home_req_s, home_here_s, home_clr_s;
    logic clr_car_en_s, serve_fwd_s, serve_rev_s;

    elev_call_reg #(
        .NUM_FLOORS(NUM_FLOORS),
        .FLOOR_W   (FLOOR_W)
    ) u_call_reg (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .hall_valid_i (hall_valid_i),
        .hall_floor_i (hall_floor_i),
        .hall_up_i    (hall_up_i),
        .car_valid_i  (car_valid_i),
        .car_floor_i  (car_floor_i),
        .cur_floor_i  (current_floor_i),
        .absorb_i     (state_q == DOOR),
        .dir_up_i     (dir_q),
        .clr_up_i     (clr_up_s),
        .clr_dn_i     (clr_dn_s),
        .clr_car_i    (clr_car_s),
        .up_pending_o (up_s),
        .dn_pending_o (dn_s),
        .car_pending_o(car_s),
        .cf_oh_o      (cf_oh_s),
        .above_o      (above_reg_s),
        .below_o      (below_reg_s)
    );

    // The pending home return counts as a call for direction decisions only.
    assign above_s     = above_reg_s || (home_req_s && (HOME_F > current_floor_i));
    assign below_s     = below_reg_s || (home_req_s && (HOME_F < current_floor_i));
    assign ahead_s     = dir_q ? above_s : below_s;
    assign behind_s    = dir_q ? below_s : above_s;
    assign up_here_s   = |(up_s & cf_oh_s);
    assign dn_here_s   = |(dn_s & cf_oh_s);
    assign car_here_s  = |(car_s & cf_oh_s);
    assign call_here_s = up_here_s || dn_here_s || car_here_s;
    assign fwd_here_s  = dir_q ? up_here_s : dn_here_s;
    assign rev_here_s  = dir_q ? dn_here_s : up_here_s;
    assign end_floor_s = dir_q ? (current_floor_i == TOP_F) : (current_floor_i == {FLOOR_W{1'b0}});
    assign any_call_s  = |(up_s | dn_s | car_s);
    assign home_here_s = home_req_s && (current_floor_i == HOME_F);

    // Next-state and registered-output logic of the SCAN controller.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        move_d       = move_q;
        open_d       = open_q;
        ack_d        = 1'b0;
        clr_car_en_s = 1'b0;
        serve_fwd_s  = 1'b0;
        serve_rev_s  = 1'b0;
        home_clr_s   = 1'b0;
        case (state_q)
            IDLE: begin
                move_d     = 1'b0;
                open_d     = 1'b0;
                home_clr_s = home_here_s;
                if (call_here_s) begin
                    state_d      = DOOR;
                    open_d       = 1'b1;
                    ack_d        = 1'b1;
                    clr_car_en_s = 1'b1;
                    serve_fwd_s  = fwd_here_s;
                    serve_rev_s  = !fwd_here_s && rev_here_s;
                    dir_d        = serve_rev_s ? ~dir_q : dir_q;
                end else if (ahead_s) begin
                    state_d = dir_q ? MOVE_UP : MOVE_DN;
                    move_d  = 1'b1;
                end else if (behind_s) begin
                    state_d = dir_q ? MOVE_DN : MOVE_UP;
                    dir_d   = ~dir_q;
                    move_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE_UP, MOVE_DN: begin
                move_d = 1'b1;
                open_d = 1'b0;
                if (!arrived_i) begin
                    state_d = state_q;
                end else if (home_here_s && !call_here_s) begin
                    state_d    = IDLE;
                    move_d     = 1'b0;
                    home_clr_s = 1'b1;
                end else if (car_here_s || fwd_here_s || (!ahead_s && rev_here_s) || end_floor_s) begin
                    state_d      = DOOR;
                    move_d       = 1'b0;
                    open_d       = 1'b1;
                    ack_d        = 1'b1;
                    clr_car_en_s = 1'b1;
                    home_clr_s   = home_here_s;
                    serve_fwd_s  = fwd_here_s;
                    serve_rev_s  = !fwd_here_s && !ahead_s && rev_here_s;
                    dir_d        = serve_rev_s ? ~dir_q : dir_q;
                end else begin
                    state_d = state_q;
                end
            end
            DOOR: begin
                move_d = 1'b0;
                if (door_done_i) begin
                    state_d = IDLE;
                    open_d  = 1'b0;
                end else begin
                    state_d = DOOR;
                    open_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                move_d  = 1'b0;
                open_d  = 1'b0;
            end
        endcase
    end

    // The served hall bit is the one matching dir_q before any reversal flip.
    assign clr_car_s = clr_car_en_s ? cf_oh_s : '0;
    assign clr_up_s  = ((serve_fwd_s && dir_q) || (serve_rev_s && !dir_q)) ? cf_oh_s : '0;
    assign clr_dn_s  = ((serve_fwd_s && !dir_q) || (serve_rev_s && dir_q)) ? cf_oh_s : '0;

    // FSM state and registered control outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            move_q  <= 1'b0;
            open_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            move_q  <= move_d;
            open_q  <= open_d;
            ack_q   <= ack_d;
        end
    end

`ifdef ELEV_IDLE_RETURN_EN
    localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             home_req_q, home_req_d;

    // Idle timer: counts quiet IDLE cycles and raises the home return request.
    always_comb begin
        idle_cnt_d = '0;
        home_req_d = home_req_q && !home_clr_s;
        if ((state_q == IDLE) && !any_call_s && !home_req_q && !hall_valid_i && !car_valid_i) begin
            if (idle_cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
                idle_cnt_d = '0;
                home_req_d = (current_floor_i != HOME_F);
            end else begin
                idle_cnt_d = idle_cnt_q + CNT_W'(1);
            end
        end else begin
            idle_cnt_d = '0;
        end
    end

    // Idle timer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_cnt_q <= '0;
            home_req_q <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            home_req_q <= home_req_d;
        end
    end

    assign home_req_s = home_req_q;
`else
    logic unused_s;

    assign home_req_s = 1'b0;
    assign unused_s   = ^{home_clr_s, any_call_s, IDLE_TIMEOUT[0]};
`endif

    assign move_req_o    = move_q;
    assign dir_up_o      = dir_q;
    assign open_door_o   = open_q;
    assign stop_ack_o    = ack_q;
    assign up_pending_o  = up_s;
    assign dn_pending_o  = dn_s;
    assign car_pending_o = car_s;

endmodule
